// File: rtl/serial_tx_piso.sv
// serial_tx_piso: parallel-in serial-out frame transmitter (start 0, DATA_W bits LSB first, stop 1).
// Ports: clk, rst_n (async active-low); in_data/in_valid/in_ready word handshake;
//        tx serial line (idles high); busy while a frame is in progress; done one-clock pulse
//        on the first IDLE clock after the stop bit.
// Macro SERIAL_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module serial_tx_piso #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bidx, bidx_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic tx_n, done_n, wrap, last;
`ifdef SERIAL_TX_PARITY_EN
  logic par, par_n;
`endif
  assign wrap = cnt == CW'(CLKS_PER_BIT - 1);
  assign last = bidx == BW'(DATA_W - 1);
  // tx is registered, so each transition loads the level of the bit being entered.
  always_comb begin
    state_n = state;
    cnt_n   = (state == IDLE || wrap) ? '0 : cnt + 1'b1;
    bidx_n  = bidx;
    sh_n    = sh;
    tx_n    = tx;
    done_n  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        tx_n = ~in_valid;
        if (in_valid) begin
          state_n = START;
          sh_n    = in_data;
          bidx_n  = '0;
`ifdef SERIAL_TX_PARITY_EN
          par_n   = ^in_data;
`endif
        end
      end
      START: if (wrap) begin
        state_n = DATA;
        tx_n    = sh[0];
      end
      DATA: if (wrap) begin
        sh_n   = sh >> 1;
        bidx_n = bidx + 1'b1;
        tx_n   = sh_n[0];
        if (last) begin
`ifdef SERIAL_TX_PARITY_EN
          state_n = PARITY;
          tx_n    = par;
`else
          state_n = STOP;
          tx_n    = 1'b1;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (wrap) begin
        state_n = STOP;
        tx_n    = 1'b1;
      end
`endif
      STOP: if (wrap) begin
        state_n = IDLE;
        tx_n    = 1'b1;
        done_n  = 1'b1;
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bidx     <= '0;
      sh       <= '0;
      tx       <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bidx     <= bidx_n;
      sh       <= sh_n;
      tx       <= tx_n;
      in_ready <= state_n == IDLE;
      busy     <= state_n != IDLE;
      done     <= done_n;
`ifdef SERIAL_TX_PARITY_EN
      par      <= par_n;
`endif
    end
  end
endmodule

// File: tb/tb_serial_tx_piso.sv
// tb_serial_tx_piso: frame-level reference model checks two transmitter configurations cycle by cycle.
module tb_serial_tx_piso;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] dat [2];
  logic val [2];
  logic [1:0] tx, rdy, bsy, dn;
  logic m_tx [2], m_rdy [2], m_busy [2], m_done [2];
  logic [127:0] fr [2];
  int len [2], pos [2], hs [2];
  int dwv [2] = '{8, 4};
  int cpv [2] = '{4, 1};
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  serial_tx_piso #(.DATA_W(8), .CLKS_PER_BIT(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(dat[0][7:0]), .in_valid(val[0]),
    .in_ready(rdy[0]), .tx(tx[0]), .busy(bsy[0]), .done(dn[0]));
  serial_tx_piso #(.DATA_W(4), .CLKS_PER_BIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(dat[1][3:0]), .in_valid(val[1]),
    .in_ready(rdy[1]), .tx(tx[1]), .busy(bsy[1]), .done(dn[1]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Expected line levels, one entry per clock: start, data LSB first, optional parity, stop.
  function automatic logic [127:0] build(input int dw, input int cpb, input logic [31:0] d, output int n);
    logic [127:0] f;
    logic b, p;
    int nb;
    f = '0;
    n = 0;
    p = 1'b0;
    for (int j = 0; j < dw; j++) p ^= d[j];
    nb = dw + 2;
`ifdef SERIAL_TX_PARITY_EN
    nb = dw + 3;
`endif
    for (int k = 0; k < nb; k++) begin
      b = (k == 0) ? 1'b0 : (k <= dw) ? d[k-1] : (k == dw + 1 && nb == dw + 3) ? p : 1'b1;
      for (int c = 0; c < cpb; c++) begin
        f[n] = b;
        n++;
      end
    end
    return f;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    logic [127:0] f;
    int n;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_tx[i] <= 1'b1; m_rdy[i] <= 1'b1; m_busy[i] <= 1'b0; m_done[i] <= 1'b0;
        pos[i] <= 0; len[i] <= 0;
      end else if (m_rdy[i] && val[i]) begin
        f = build(dwv[i], cpv[i], dat[i], n);
        fr[i] <= f; len[i] <= n; pos[i] <= 1; m_tx[i] <= f[0];
        m_rdy[i] <= 1'b0; m_busy[i] <= 1'b1; m_done[i] <= 1'b0; hs[i] <= hs[i] + 1;
      end else if (pos[i] < len[i]) begin
        m_tx[i] <= fr[i][pos[i]]; pos[i] <= pos[i] + 1; m_done[i] <= 1'b0;
      end else begin
        m_done[i] <= m_busy[i]; m_busy[i] <= 1'b0; m_rdy[i] <= 1'b1; m_tx[i] <= 1'b1;
        len[i] <= 0; pos[i] <= 0;
      end
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("tx%0d", i), 32'(tx[i]), 32'(m_tx[i]));
      chk($sformatf("in_ready%0d", i), 32'(rdy[i]), 32'(m_rdy[i]));
      chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_busy[i]));
      chk($sformatf("done%0d", i), 32'(dn[i]), 32'(m_done[i]));
    end
  end
  task automatic send(input int i, input logic [31:0] d, input bit hold);
    int h0, t;
    h0 = hs[i];
    t = 0;
    dat[i] = d;
    val[i] = 1'b1;
    while (hs[i] == h0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (hs[i] == h0) chk("accept_timeout", 32'(t), 32'(0));
    if (!hold) val[i] = 1'b0;
  endtask
  task automatic wait_idle(input int i);
    int t;
    t = 0;
    while ((m_busy[i] || m_done[i]) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (m_busy[i]) chk("idle_timeout", 32'(t), 32'(0));
  endtask
  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_tx", 32'(tx[i]), 32'(1));
      chk("rst_in_ready", 32'(rdy[i]), 32'(1));
      chk("rst_busy", 32'(bsy[i]), 32'(0));
      chk("rst_done", 32'(dn[i]), 32'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] d;
    int gap;
    for (int i = 0; i < 2; i++) begin
      val[i] = 1'b0; dat[i] = '0; hs[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    pulse_reset();
    repeat (8) @(negedge clk);
    send(0, 32'hA5, 1'b0);
    wait_idle(0);
    send(0, 32'h0F, 1'b0);
    dat[0] = 32'hFF;
    val[0] = 1'b1;
    repeat (20) @(negedge clk);
    val[0] = 1'b0;
    wait_idle(0);
    send(0, 32'h01, 1'b1);
    send(0, 32'h80, 1'b0);
    wait_idle(0);
    send(0, 32'h3C, 1'b0);
    repeat (17) @(negedge clk);
    pulse_reset();
    repeat (3) @(negedge clk);
    send(0, 32'hC3, 1'b0);
    wait_idle(0);
    send(1, 32'h7, 1'b0);
    wait_idle(1);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 25; k++) begin
        d = $urandom;
        gap = $urandom_range(0, 2);
        send(i, d, gap == 0);
        if (gap != 0) begin
          wait_idle(i);
          repeat (gap) @(negedge clk);
        end
      end
      val[i] = 1'b0;
      wait_idle(i);
    end
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_tx_piso.md
Name: serial_tx_piso

Overview:
- Parallel-in, serial-out frame transmitter; the transmit end of the team's serial bit link.
- Accepts one DATA_W-bit word over a valid/ready handshake.
- Emits one frame on a single line, LSB first: start bit (0), data bits, stop bit (1), each held CLKS_PER_BIT clocks.
- Feeds the matching serial-in/parallel-out capture block.

Parameters:
- DATA_W, 8: payload bits per frame; legal range 1..32.
- CLKS_PER_BIT, 4: clocks per serial bit; legal minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  word to transmit; sampled only on handshake.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word (high only in IDLE).
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress (any state except IDLE).
- done  output  1  one-clock pulse when a frame's stop bit completes.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- Reset (rst_n low, takes effect immediately, no clock needed):
  - tx=1, in_ready=1, busy=0, done=0, state=IDLE.
  - Bit counter, shift register and divider counter cleared.
- Reset mid-frame: frame is abandoned, tx returns to 1 at once, nothing is resumed after release.
- All outputs are registered. States: IDLE, START, DATA, STOP (plus PARITY when the feature is enabled).
- IDLE:
  - tx=1, in_ready=1, busy=0.
  - Handshake fires on a clock edge where in_valid=1 and in_ready=1: latch in_data into the shift register and go to START.
- START:
  - tx=0 for CLKS_PER_BIT clocks, beginning the clock after the handshake.
  - in_ready=0 and busy=1 from the handshake edge onward.
- DATA:
  - DATA_W bits, shift register bit 0 first, each held CLKS_PER_BIT clocks.
  - Shift right once per bit period.
  - Bit index runs 0..DATA_W-1; when the last bit's period expires, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT clocks, then go to IDLE.
  - done=1 for exactly the first clock in IDLE.
- Divider:
  - Counter runs 0..CLKS_PER_BIT-1 and wraps; the state/bit advance happens on the wrap.
  - With CLKS_PER_BIT=1 the counter is constant 0 and every bit lasts one clock.
- Frame length: (DATA_W+2)*CLKS_PER_BIT clocks from the clock after the handshake to the return to IDLE.
- Back-to-back:
  - in_ready is high in the same clock as done.
  - A word offered then is accepted, so tx goes 1 → 0 with exactly one IDLE clock at tx=1 between frames (one clock beyond the stop bit).
- in_data and in_valid are ignored while busy. Words presented while in_ready=0 are not queued; the source holds in_valid.
- in_valid may drop without a handshake; no side effects.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the latched DATA_W bits (even parity), held CLKS_PER_BIT clocks.
  - Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- Undefined:
  - No PARITY state and no parity logic; frame exactly as above.

Test Plan (DATA_W=8, CLKS_PER_BIT=4 unless stated):
1. Reset: assert rst_n=0 mid-simulation between clock edges → tx=1, in_ready=1, busy=0, done=0 immediately. Release → tx stays 1 and no done pulse while in_valid=0.
2. Single frame: in_data=8'hA5, in_valid pulse for one handshake clock.
   - tx after the handshake = 0 for 4 clocks, then 1,0,1,0,0,1,0,1 (4 clocks each), then 1 for 4 clocks.
   - done pulses once, 40 clocks after the handshake; busy high for those 40 clocks.
3. Busy-ignore: during the frame of 8'h0F, drive in_data=8'hFF with in_valid=1 → serialized bits remain 1,1,1,1,0,0,0,0; in_ready stays 0 until IDLE.
4. Back-to-back: hold in_valid=1 with 8'h01 then 8'h80 → second start bit begins one clock after the first frame's stop period; second data reads 0,0,0,0,0,0,0,1.
5. Reset mid-frame: assert rst_n=0 during data bit 3 of 8'h3C → tx=1 at once. After release, a new frame of 8'hC3 transmits correctly with no residue of 8'h3C.
6. CLKS_PER_BIT=1, DATA_W=4, SERIAL_TX_PARITY_EN defined: send 4'b0111 → tx sequence 0,1,1,1,0,1(parity),1(stop), one clock each; done pulses 7 clocks after the handshake.
